// File: rtl/pll_drp_if.sv
// Requester-side bus of the PLL DRP arbiter: per-requester request/response lanes.
// The N_REQ of the interface instance must equal that of the arbiter.
interface pll_drp_if #(
  parameter int N_REQ = 2
) ();
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_we;
  logic [7*N_REQ-1:0]  req_addr;
  logic [16*N_REQ-1:0] req_di;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ-1:0]    req_pll_rst;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    resp_valid;
  logic [15:0]         resp_do;
  logic                resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_di, req_lock, req_pll_rst,
    input  req_ready, grant, resp_valid, resp_do, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_di, req_lock, req_pll_rst,
    output req_ready, grant, resp_valid, resp_do, resp_err
  );
endinterface

// File: rtl/pll_drp_arbiter.sv
// Round-robin arbiter sharing one PLLE2_ADV DRP port among N_REQ requesters,
// with owner lock for read-modify-write, drdy timeout and owner-driven PLL reset.
module pll_drp_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  pll_drp_if.slave    bus,
  output logic        den,
  output logic        dwe,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  input  logic [15:0] do_i,
  input  logic        drdy,
  output logic        pll_rst
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [IW-1:0]    owner_reg, owner_next;
  logic [IW-1:0]    rr_reg, rr_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [N_REQ-1:0] resp_valid_reg, resp_valid_next;
  logic [15:0]      resp_do_reg, resp_do_next;
  logic             resp_err_reg, resp_err_next;
  logic             den_reg, den_next;
  logic             dwe_reg, dwe_next;
  logic             wr_reg, wr_next;
  logic [6:0]       daddr_reg, daddr_next;
  logic [15:0]      di_reg, di_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic             pll_rst_reg, pll_rst_next;

  logic [6:0]  addr_arr  [N_REQ];
  logic [15:0] wdata_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign addr_arr[gi]  = bus.req_addr[7*gi +: 7];
      assign wdata_arr[gi] = bus.req_di[16*gi +: 16];
    end
  endgenerate

  // First requesting index at or after rr_reg, wrapping; lowest offset wins.
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_reg} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (bus.req_valid[cand[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  logic          own_valid, own_we, own_lock;
  logic [IW-1:0] rr_after_owner;

  assign own_valid      = bus.req_valid[owner_reg];
  assign own_we         = bus.req_we[owner_reg];
  assign own_lock       = bus.req_lock[owner_reg];
  assign rr_after_owner = (owner_reg == LAST_IDX) ? '0 : owner_reg + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= '0;
      rr_reg         <= '0;
      grant_reg      <= '0;
      resp_valid_reg <= '0;
      resp_do_reg    <= '0;
      resp_err_reg   <= 1'b0;
      den_reg        <= 1'b0;
      dwe_reg        <= 1'b0;
      wr_reg         <= 1'b0;
      daddr_reg      <= '0;
      di_reg         <= '0;
      timer_reg      <= '0;
      pll_rst_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      rr_reg         <= rr_next;
      grant_reg      <= grant_next;
      resp_valid_reg <= resp_valid_next;
      resp_do_reg    <= resp_do_next;
      resp_err_reg   <= resp_err_next;
      den_reg        <= den_next;
      dwe_reg        <= dwe_next;
      wr_reg         <= wr_next;
      daddr_reg      <= daddr_next;
      di_reg         <= di_next;
      timer_reg      <= timer_next;
      pll_rst_reg    <= pll_rst_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    rr_next         = rr_reg;
    grant_next      = grant_reg;
    resp_valid_next = '0;
    resp_do_next    = '0;
    resp_err_next   = 1'b0;
    den_next        = 1'b0;
    dwe_next        = 1'b0;
    wr_next         = wr_reg;
    daddr_next      = daddr_reg;
    di_next         = di_reg;
    timer_next      = timer_reg;

    case (state_reg)
      ST_IDLE: begin
        grant_next = '0;
        if (pick_valid) begin
          owner_next           = pick_idx;
          grant_next[pick_idx] = 1'b1;
          state_next           = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (own_valid) begin
          den_next   = 1'b1;
          dwe_next   = own_we;
          wr_next    = own_we;
          daddr_next = addr_arr[owner_reg];
          di_next    = wdata_arr[owner_reg];
          timer_next = '0;
          state_next = ST_WAIT;
        end else if (!own_lock) begin
          grant_next = '0;
          rr_next    = rr_after_owner;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Timer starts the cycle after den, so an abort lands TIMEOUT+1 cycles after den.
        if (drdy || (!den_reg && timer_reg == TIMER_END)) begin
          resp_valid_next = grant_reg;
          resp_err_next   = !drdy;
          resp_do_next    = (drdy && !wr_reg) ? do_i : 16'h0000;
          if (own_lock) begin
            state_next = ST_GRANT;
          end else begin
            grant_next = '0;
            rr_next    = rr_after_owner;
            state_next = ST_IDLE;
          end
        end else if (!den_reg) begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase

    pll_rst_next = (state_next == ST_IDLE) ? 1'b0 : bus.req_pll_rst[owner_next];
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_reg == ST_GRANT) begin
      bus.req_ready[owner_reg] = own_valid;
    end
  end

  assign bus.grant      = grant_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_do    = resp_do_reg;
  assign bus.resp_err   = resp_err_reg;
  assign den            = den_reg;
  assign dwe            = dwe_reg;
  assign daddr          = daddr_reg;
  assign di             = di_reg;
  assign pll_rst        = pll_rst_reg;
endmodule

// File: tb/tb_pll_drp_arbiter.sv
// Scoreboard bench for pll_drp_arbiter: a PLL DRP model with programmable drdy
// delay, directed scenarios and randomized contention rounds.
module tb_pll_drp_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pll_drp_if #(.N_REQ(N)) bus ();
  logic        den, dwe, drdy, pll_rst;
  logic [6:0]  daddr;
  logic [15:0] di, do_i;

  pll_drp_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .den    (den),
    .dwe    (dwe),
    .daddr  (daddr),
    .di     (di),
    .do_i   (do_i),
    .drdy   (drdy),
    .pll_rst(pll_rst)
  );

  typedef struct {
    int          owner;
    logic [15:0] dout;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem_ref [128];
  int          rr_model;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          den_cnt, den_cyc, resp_cnt, resp_cyc, viol;
  bit          lock_watch;
  int          pll_delay;
  bit          inject;
  int          dly_tab [7];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int a);
    logic [6:0] a7;
    a7 = 7'(a);
    return {a7, 9'h041};
  endfunction

  // PLL DRP model: drdy pll_delay cycles after den (0 = never), writes land on den.
  initial begin : pll_model
    logic [15:0] pll_mem [128];
    int          pend;
    logic [6:0]  pend_addr;
    logic        pend_we;
    for (int a = 0; a < 128; a++) pll_mem[a] = init_val(a);
    drdy = 1'b0; do_i = '0; pend = 0; pend_addr = '0; pend_we = 1'b0;
    forever begin
      @(negedge clk);
      drdy = 1'b0;
      if (inject) begin
        drdy = 1'b1; do_i = 16'hABCD; inject = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drdy = 1'b1;
          do_i = pend_we ? 16'hDEAD : pll_mem[pend_addr];
        end
      end
      if (den) begin
        pend_addr = daddr; pend_we = dwe; pend = pll_delay;
        if (dwe) pll_mem[daddr] = di;
      end
    end
  end

  // Response / den monitor: pops the scoreboard whenever resp_valid is seen.
  initial begin : monitor
    exp_t       e;
    logic [N-1:0] oh;
    logic       den_prev;
    den_cnt = 0; resp_cnt = 0; den_prev = 1'b0; viol = 0;
    forever begin
      @(negedge clk);
      if (lock_watch && bus.req_ready[0]) viol++;
      if (den) begin
        checks++;
        if (den_prev) begin
          errors++;
          $display("FAIL den_pulse den high in consecutive cycles at cyc %0d, required single cycle", cyc);
        end
        den_cnt++; den_cyc = cyc;
      end
      den_prev = den;
      if (|bus.resp_valid) begin
        resp_cnt++; resp_cyc = cyc; checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected resp_valid=%b do=%h err=%b, required no response",
                   bus.resp_valid, bus.resp_do, bus.resp_err);
        end else begin
          e = sb.pop_front();
          oh = '0; oh[e.owner] = 1'b1;
          if (bus.resp_valid !== oh || bus.resp_do !== e.dout || bus.resp_err !== e.err) begin
            errors++;
            $display("FAIL resp actual valid=%b do=%h err=%b required valid=%b do=%h err=%b",
                     bus.resp_valid, bus.resp_do, bus.resp_err, oh, e.dout, e.err);
          end else begin
            $display("RESP cyc=%0d owner=%0d do=%h err=%b", cyc, e.owner, bus.resp_do, bus.resp_err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input logic [6:0] a, input logic [15:0] d);
    bus.req_valid[i]         = v;
    bus.req_we[i]            = we;
    bus.req_addr[7*i +: 7]   = a;
    bus.req_di[16*i +: 16]   = d;
  endtask

  task automatic push_exp(input int o, input bit we, input logic [6:0] a, input logic [15:0] d, input bit err);
    exp_t e;
    e.owner = o;
    e.err   = err;
    e.dout  = (we || err) ? 16'h0000 : mem_ref[a];
    if (we) mem_ref[a] = d;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int i, input string name);
    int n = 0;
    #1;
    while (!bus.req_ready[i] && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.req_ready[i]) begin
      checks++; errors++;
      $display("FAIL %s req_ready[%0d] actual=0 required=1 within 200 cycles", name, i);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s pending responses actual=%0d required=0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic single(input int i, input bit we, input logic [6:0] a, input logic [15:0] d, input bit err);
    push_exp(i, we, a, d, err);
    set_req(i, 1'b1, we, a, d);
    wait_ready(i, "single_ready");
    @(negedge clk);
    bus.req_valid[i] = 1'b0;
    wait_drain("single_drain");
    if (!bus.req_lock[i]) rr_model = (i + 1) % N;
  endtask

  task automatic round(input bit [N-1:0] mask, input int dly);
    bit          we_a [N];
    logic [6:0]  a_a  [N];
    logic [15:0] d_a  [N];
    bit          err;
    bit [N-1:0]  pending, clr;
    int          idx, last, n;
    pll_delay = dly;
    err = (dly == 0) || (dly > TO);
    last = 0;
    for (int i = 0; i < N; i++) begin
      we_a[i] = 1'($urandom_range(0, 1));
      a_a[i]  = 7'($urandom_range(0, 7));
      d_a[i]  = 16'($urandom);
    end
    for (int k = 0; k < N; k++) begin
      idx = (rr_model + k) % N;
      if (mask[idx]) begin
        push_exp(idx, we_a[idx], a_a[idx], d_a[idx], err);
        last = idx;
      end
    end
    rr_model = (last + 1) % N;
    $display("ROUND mask=%b drdy_delay=%0d expect_err=%b", mask, dly, err);
    for (int i = 0; i < N; i++) if (mask[i]) set_req(i, 1'b1, we_a[i], a_a[i], d_a[i]);
    pending = mask; clr = '0; n = 0;
    while ((pending != 0 || sb.size() != 0) && n < 1000) begin
      @(negedge clk); n++;
      for (int i = 0; i < N; i++) begin
        if (clr[i]) begin bus.req_valid[i] = 1'b0; clr[i] = 1'b0; end
      end
      for (int i = 0; i < N; i++) begin
        if (pending[i] && bus.req_ready[i]) begin clr[i] = 1'b1; pending[i] = 1'b0; end
      end
    end
    bus.req_valid = '0;
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL round_timeout pending=%b responses_left=%0d required 0", pending, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin : stim
    int c0, d0, r0;
    dly_tab[0] = 0; dly_tab[1] = 1; dly_tab[2] = 2; dly_tab[3] = 3;
    dly_tab[4] = 5; dly_tab[5] = TO; dly_tab[6] = TO + 1;
    for (int a = 0; a < 128; a++) mem_ref[a] = init_val(a);
    rr_model = 0; pll_delay = 3; inject = 1'b0; lock_watch = 1'b0;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_di = '0;
    bus.req_lock = '0; bus.req_pll_rst = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_den", 32'(den), 0);
    chk("rst_pll_rst", 32'(pll_rst), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 single read with minimum latency
    pll_delay = 3;
    c0 = cyc; d0 = den_cnt;
    single(0, 1'b0, 7'h08, 16'h0000, 1'b0);
    chk("t1_den_latency", 32'(den_cyc - c0), 2);
    chk("t1_resp_after_den", 32'(resp_cyc - den_cyc), 4);
    chk("t1_den_count", 32'(den_cnt - d0), 1);

    // T2 contention and rotation
    round(3'b011, 2);
    round(3'b011, 2);
    round(3'b111, 1);

    // T3 locked read-modify-write with a competing requester
    pll_delay = 2;
    bus.req_lock[1] = 1'b1;
    lock_watch = 1'b1;
    push_exp(1, 1'b0, 7'h09, 16'h0000, 1'b0);
    set_req(1, 1'b1, 1'b0, 7'h09, 16'h0000);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 7'h20, 16'h0000);
    chk("t3_grant_req1", 32'(bus.grant), 32'h2);
    wait_ready(1, "t3_read_ready");
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    wait_drain("t3_read");
    chk("t3_grant_kept", 32'(bus.grant), 32'h2);
    push_exp(1, 1'b1, 7'h09, 16'h0080, 1'b0);
    set_req(1, 1'b1, 1'b1, 7'h09, 16'h0080);
    wait_ready(1, "t3_write_ready");
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    wait_drain("t3_write");
    push_exp(0, 1'b0, 7'h20, 16'h0000, 1'b0);
    lock_watch = 1'b0;
    bus.req_lock[1] = 1'b0;
    wait_ready(0, "t3_req0_ready");
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    wait_drain("t3_req0");
    chk("t3_req0_ready_while_locked", 32'(viol), 0);
    rr_model = 1;
    single(0, 1'b0, 7'h09, 16'h0000, 1'b0);

    // T4 timeout, then a late drdy
    pll_delay = 0;
    single(2, 1'b0, 7'h10, 16'h0000, 1'b1);
    chk("t4_timeout_latency", 32'(resp_cyc - den_cyc), TO + 1);
    r0 = resp_cnt;
    inject = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_late_drdy_ignored", 32'(resp_cnt - r0), 0);

    // T5 PLL reset held under lock
    pll_delay = 1;
    bus.req_lock[2] = 1'b1;
    bus.req_pll_rst[2] = 1'b1;
    set_req(2, 1'b1, 1'b0, 7'h05, 16'h0000);
    push_exp(2, 1'b0, 7'h05, 16'h0000, 1'b0);
    @(negedge clk);
    chk("t5_grant", 32'(bus.grant), 32'h4);
    chk("t5_pll_rst_on", 32'(pll_rst), 1);
    wait_ready(2, "t5_ready");
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    wait_drain("t5_access");
    chk("t5_pll_rst_held", 32'(pll_rst), 1);
    chk("t5_grant_held", 32'(bus.grant), 32'h4);
    bus.req_lock[2] = 1'b0;
    @(negedge clk);
    chk("t5_grant_released", 32'(bus.grant), 0);
    chk("t5_pll_rst_idle", 32'(pll_rst), 0);
    bus.req_pll_rst[2] = 1'b0;
    rr_model = 0;
    @(negedge clk);

    // T6 reset during WAIT, then a stray drdy
    pll_delay = 0;
    set_req(1, 1'b1, 1'b1, 7'h03, 16'h5A5A);
    wait_ready(1, "t6_ready");
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(bus.grant), 0);
    chk("t6_den_dwe", 32'({den, dwe}), 0);
    chk("t6_daddr_di", 32'({daddr, di}), 0);
    chk("t6_resp", 32'({bus.resp_valid, bus.resp_do, bus.resp_err}), 0);
    chk("t6_pll_rst", 32'(pll_rst), 0);
    mem_ref[3] = 16'h5A5A;
    @(negedge clk);
    rst_n = 1'b1;
    rr_model = 0;
    r0 = resp_cnt;
    inject = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_drdy_after_reset", 32'(resp_cnt - r0), 0);

    // Randomized contention rounds
    for (int r = 0; r < 25; r++) begin
      round(3'($urandom_range(1, 7)), dly_tab[$urandom_range(0, 6)]);
    end

    chk("final_scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
